// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle controller slice.
//   - state_t        : controller FSM states (HALT only exists with the trap build)
//   - instr_class_t  : coarse instruction class produced by instr_decoder
//   - OP_* / F_*     : opcode and R-type funct encodings
//   - ALU_*          : 4-bit ALUOp encodings driven to the datapath
// Configuration macro: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN (adds the HALT state).
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    , HALT
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_ADDI,
    CLS_J,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational opcode/funct decode.
//   opcode      in  [5:0]  instruction bits [31:26]
//   funct       in  [5:0]  instruction bits [5:0]
//   instr_class out        coarse class used by the controller FSM
//   alu_op      out [3:0]  ALU operation for the EXEC..WB window
//   legal       out        1 when opcode (and funct for R-type) is supported
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t instr_class,
  output logic [3:0]   alu_op,
  output logic         legal
);

  always_comb begin
    instr_class = CLS_ILLEGAL;
    alu_op      = ALU_AND;
    legal       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        instr_class = CLS_RTYPE;
        legal       = 1'b1;
        case (funct)
          F_ADD:   alu_op = ALU_ADD;
          F_SUB:   alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_SLT:   alu_op = ALU_SLT;
          default: begin
            instr_class = CLS_ILLEGAL;
            legal       = 1'b0;
          end
        endcase
      end
      OP_LW:   begin instr_class = CLS_LW;   alu_op = ALU_ADD; legal = 1'b1; end
      OP_SW:   begin instr_class = CLS_SW;   alu_op = ALU_ADD; legal = 1'b1; end
      OP_BEQ:  begin instr_class = CLS_BEQ;  alu_op = ALU_SUB; legal = 1'b1; end
      OP_ADDI: begin instr_class = CLS_ADDI; alu_op = ALU_ADD; legal = 1'b1; end
      OP_J:    begin instr_class = CLS_J;    legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB controller for a MIPS-like
// multicycle datapath. Owns pc and the instruction register.
//   clk, rst_n       single clock, async active-low reset
//   ins_in/ins_valid instruction memory return
//   zero             ALU zero flag (sampled in EXEC for beq)
//   fetch_req, pc    fetch request and address
//   ins              instruction register
//   MemtoReg..RegWrite, ALUOp  datapath controls (registered)
//   illegal          trap flag (tied 0 unless MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN)
// Configuration macro: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins_in,
  input  logic        ins_valid,
  input  logic        zero,
  output logic        fetch_req,
  output logic [31:0] pc,
  output logic [31:0] ins,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        Branch,
  output logic        ALUSrc,
  output logic        RegDst,
  output logic        RegWrite,
  output logic [3:0]  ALUOp,
  output logic        illegal
);

  state_t       state;
  instr_class_t dec_class;
  logic [3:0]   dec_alu_op;
  logic         dec_legal;

  instr_decoder u_dec (
    .opcode      (ins[31:26]),
    .funct       (ins[5:0]),
    .instr_class (dec_class),
    .alu_op      (dec_alu_op),
    .legal       (dec_legal)
  );

`ifndef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  // Outputs are registered, so each transition writes the control values
  // that belong to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ins       <= '0;
      fetch_req <= 1'b0;
      MemtoReg  <= 1'b0;
      MemWrite  <= 1'b0;
      Branch    <= 1'b0;
      ALUSrc    <= 1'b0;
      RegDst    <= 1'b0;
      RegWrite  <= 1'b0;
      ALUOp     <= ALU_AND;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
      illegal   <= 1'b0;
`endif
    end else begin
      MemWrite <= 1'b0;
      RegWrite <= 1'b0;
      Branch   <= 1'b0;
      case (state)
        FETCH: begin
          fetch_req <= 1'b1;
          // fetch_req low here only on the first cycle out of reset; no accept then.
          if (fetch_req && ins_valid) begin
            ins       <= ins_in;
            pc        <= pc + 32'd4;
            fetch_req <= 1'b0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          if (!dec_legal) begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            illegal <= 1'b1;
            state   <= HALT;
`else
            fetch_req <= 1'b1;
            state     <= FETCH;
`endif
          end else if (dec_class == CLS_J) begin
            pc        <= {pc[31:28], ins[25:0], 2'b00};
            fetch_req <= 1'b1;
            state     <= FETCH;
          end else begin
            // RegDst/MemtoReg are set here so they stay constant through WB.
            ALUOp    <= dec_alu_op;
            ALUSrc   <= (dec_class == CLS_LW) || (dec_class == CLS_SW) || (dec_class == CLS_ADDI);
            RegDst   <= (dec_class == CLS_LW) || (dec_class == CLS_ADDI);
            MemtoReg <= (dec_class == CLS_LW);
            Branch   <= (dec_class == CLS_BEQ);
            state    <= EXEC;
          end
        end
        EXEC: begin
          case (dec_class)
            CLS_RTYPE, CLS_ADDI: begin
              RegWrite <= 1'b1;
              state    <= WB;
            end
            CLS_LW, CLS_SW: begin
              MemWrite <= (dec_class == CLS_SW);
              state    <= MEM;
            end
            default: begin
              if (dec_class == CLS_BEQ && zero)
                pc <= pc + {{14{ins[15]}}, ins[15:0], 2'b00};
              ALUOp <= ALU_AND; ALUSrc <= 1'b0; RegDst <= 1'b0; MemtoReg <= 1'b0;
              fetch_req <= 1'b1;
              state     <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (dec_class == CLS_LW) begin
            RegWrite <= 1'b1;
            state    <= WB;
          end else begin
            ALUOp <= ALU_AND; ALUSrc <= 1'b0; RegDst <= 1'b0; MemtoReg <= 1'b0;
            fetch_req <= 1'b1;
            state     <= FETCH;
          end
        end
        WB: begin
          ALUOp <= ALU_AND; ALUSrc <= 1'b0; RegDst <= 1'b0; MemtoReg <= 1'b0;
          fetch_req <= 1'b1;
          state     <= FETCH;
        end
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        HALT: begin
          illegal   <= 1'b1;
          fetch_req <= 1'b0;
        end
`endif
        default: begin
          ALUOp <= ALU_AND; ALUSrc <= 1'b0; RegDst <= 1'b0; MemtoReg <= 1'b0;
          fetch_req <= 1'b1;
          state     <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Inputs are driven and outputs sampled on the falling clock edge.
// ctl packs {illegal, MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, ALUOp}.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins_in;
  logic        ins_valid;
  logic        zero;
  logic        fetch_req;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite;
  logic [3:0]  ALUOp;
  logic        illegal;
  logic [10:0] ctl;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] I_ADD = 32'h012A4020;
  localparam logic [31:0] I_LW  = 32'h8D280004;
  localparam logic [31:0] I_SW  = 32'hAD280008;
  localparam logic [31:0] I_BEQ = 32'h11090003;
  localparam logic [31:0] I_J10 = 32'h08000004;
  localparam logic [31:0] I_BAD = 32'hFC000000;

  always #5 clk = ~clk;

  assign ctl = {illegal, MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, ALUOp};

  multicycle_control #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ins_in    (ins_in),
    .ins_valid (ins_valid),
    .zero      (zero),
    .fetch_req (fetch_req),
    .pc        (pc),
    .ins       (ins),
    .MemtoReg  (MemtoReg),
    .MemWrite  (MemWrite),
    .Branch    (Branch),
    .ALUSrc    (ALUSrc),
    .RegDst    (RegDst),
    .RegWrite  (RegWrite),
    .ALUOp     (ALUOp),
    .illegal   (illegal)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; ins_in = '0; ins_valid = 1'b0; zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset pc: got %h expected %h", pc, 32'h0); end
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL reset ins: got %h expected %h", ins, 32'h0); end
    checks++; if (ctl !== 11'h000) begin errors++; $display("FAIL reset ctl: got %h expected %h", ctl, 11'h000); end
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset fetch_req: got %b expected 0", fetch_req); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL post-reset fetch_req: got %b expected 1", fetch_req); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL post-reset pc: got %h expected %h", pc, 32'h0); end
  endtask

  task automatic test_rtype();
    logic [10:0] ec [5];
    logic        ef [5];
    logic [31:0] ep [5];
    ec = '{11'h000, 11'h000, 11'h002, 11'h012, 11'h000};
    ef = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ep = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h4};
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (ctl !== ec[c]) begin errors++; $display("FAIL rtype ctl cycle %0d: got %h expected %h", c + 1, ctl, ec[c]); end
      checks++; if (fetch_req !== ef[c]) begin errors++; $display("FAIL rtype fetch_req cycle %0d: got %b expected %b", c + 1, fetch_req, ef[c]); end
      checks++; if (pc !== ep[c]) begin errors++; $display("FAIL rtype pc cycle %0d: got %h expected %h", c + 1, pc, ep[c]); end
      ins_in = I_ADD; ins_valid = (c < 4);
    end
    checks++; if (ins !== I_ADD) begin errors++; $display("FAIL rtype ins: got %h expected %h", ins, I_ADD); end
  endtask

  task automatic test_lw_sw();
    logic [10:0] ec [10];
    logic        ef [10];
    logic [31:0] ep [10];
    ec = '{11'h000, 11'h000, 11'h262, 11'h262, 11'h272, 11'h000, 11'h000, 11'h042, 11'h142, 11'h000};
    ef = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ep = '{32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC};
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (ctl !== ec[c]) begin errors++; $display("FAIL lw_sw ctl cycle %0d: got %h expected %h", c + 1, ctl, ec[c]); end
      checks++; if (fetch_req !== ef[c]) begin errors++; $display("FAIL lw_sw fetch_req cycle %0d: got %b expected %b", c + 1, fetch_req, ef[c]); end
      checks++; if (pc !== ep[c]) begin errors++; $display("FAIL lw_sw pc cycle %0d: got %h expected %h", c + 1, pc, ep[c]); end
      ins_in = (c < 5) ? I_LW : I_SW; ins_valid = (c < 9);
    end
  endtask

  task automatic test_beq();
    logic [10:0] ec [11];
    logic        ef [11];
    logic [31:0] ep [11];
    logic [31:0] ei [11];
    ec = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h086, 11'h000, 11'h000, 11'h000, 11'h000, 11'h086, 11'h000};
    ef = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ep = '{32'hC, 32'h10, 32'h10, 32'h14, 32'h14, 32'h20, 32'h24, 32'h10, 32'h14, 32'h14, 32'h14};
    ei = '{I_J10, I_J10, I_BEQ, I_BEQ, I_BEQ, I_J10, I_J10, I_BEQ, I_BEQ, I_BEQ, I_BEQ};
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (ctl !== ec[c]) begin errors++; $display("FAIL beq ctl cycle %0d: got %h expected %h", c + 1, ctl, ec[c]); end
      checks++; if (fetch_req !== ef[c]) begin errors++; $display("FAIL beq fetch_req cycle %0d: got %b expected %b", c + 1, fetch_req, ef[c]); end
      checks++; if (pc !== ep[c]) begin errors++; $display("FAIL beq pc cycle %0d: got %h expected %h", c + 1, pc, ep[c]); end
      ins_in = ei[c]; ins_valid = (c < 10); zero = (c < 5);
    end
    zero = 1'b0;
  endtask

  task automatic test_fetch_stall();
    logic [10:0] ec [8];
    logic        ef [8];
    logic [31:0] ep [8];
    ec = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h002, 11'h012, 11'h000};
    ef = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ep = '{32'h14, 32'h14, 32'h14, 32'h14, 32'h18, 32'h18, 32'h18, 32'h18};
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (ctl !== ec[c]) begin errors++; $display("FAIL stall ctl cycle %0d: got %h expected %h", c + 1, ctl, ec[c]); end
      checks++; if (fetch_req !== ef[c]) begin errors++; $display("FAIL stall fetch_req cycle %0d: got %b expected %b", c + 1, fetch_req, ef[c]); end
      checks++; if (pc !== ep[c]) begin errors++; $display("FAIL stall pc cycle %0d: got %h expected %h", c + 1, pc, ep[c]); end
      if (c < 4) begin
        checks++; if (ins !== I_BEQ) begin errors++; $display("FAIL stall ins held cycle %0d: got %h expected %h", c + 1, ins, I_BEQ); end
      end
      ins_in = I_ADD; ins_valid = (c >= 3) && (c < 7);
    end
  endtask

  task automatic test_reset_mid_lw();
    logic [10:0] ec [4];
    logic        ef [4];
    logic [31:0] ep [4];
    ec = '{11'h000, 11'h000, 11'h262, 11'h262};
    ef = '{1'b1, 1'b0, 1'b0, 1'b0};
    ep = '{32'h18, 32'h1C, 32'h1C, 32'h1C};
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (ctl !== ec[c]) begin errors++; $display("FAIL rst_mid ctl cycle %0d: got %h expected %h", c + 1, ctl, ec[c]); end
      checks++; if (fetch_req !== ef[c]) begin errors++; $display("FAIL rst_mid fetch_req cycle %0d: got %b expected %b", c + 1, fetch_req, ef[c]); end
      checks++; if (pc !== ep[c]) begin errors++; $display("FAIL rst_mid pc cycle %0d: got %h expected %h", c + 1, pc, ep[c]); end
      ins_in = I_LW; ins_valid = (c == 0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ctl !== 11'h000) begin errors++; $display("FAIL rst_mid async ctl: got %h expected %h", ctl, 11'h000); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_mid async pc: got %h expected %h", pc, 32'h0); end
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL rst_mid async ins: got %h expected %h", ins, 32'h0); end
    @(negedge clk);
    checks++; if (ctl !== 11'h000) begin errors++; $display("FAIL rst_mid held ctl: got %h expected %h", ctl, 11'h000); end
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rst_mid held fetch_req: got %b expected 0", fetch_req); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL rst_mid release fetch_req: got %b expected 1", fetch_req); end
    checks++; if (ctl !== 11'h000) begin errors++; $display("FAIL rst_mid release ctl: got %h expected %h", ctl, 11'h000); end
  endtask

  task automatic test_illegal();
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    logic [10:0] ec [8];
    logic        ef [8];
    ec = '{11'h000, 11'h000, 11'h400, 11'h400, 11'h400, 11'h400, 11'h400, 11'h400};
    ef = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (ctl !== ec[c]) begin errors++; $display("FAIL illegal ctl cycle %0d: got %h expected %h", c + 1, ctl, ec[c]); end
      checks++; if (fetch_req !== ef[c]) begin errors++; $display("FAIL illegal fetch_req cycle %0d: got %b expected %b", c + 1, fetch_req, ef[c]); end
      checks++; if (c > 0 && pc !== 32'h4) begin errors++; $display("FAIL illegal pc cycle %0d: got %h expected %h", c + 1, pc, 32'h4); end
      ins_in = (c == 0) ? I_BAD : I_ADD; ins_valid = 1'b1;
    end
    ins_valid = 1'b0;
`else
    logic [10:0] ec [4];
    logic        ef [4];
    logic [31:0] ep [4];
    ec = '{11'h000, 11'h000, 11'h000, 11'h000};
    ef = '{1'b1, 1'b0, 1'b1, 1'b0};
    ep = '{32'h0, 32'h4, 32'h4, 32'h8};
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (ctl !== ec[c]) begin errors++; $display("FAIL illegal ctl cycle %0d: got %h expected %h", c + 1, ctl, ec[c]); end
      checks++; if (fetch_req !== ef[c]) begin errors++; $display("FAIL illegal fetch_req cycle %0d: got %b expected %b", c + 1, fetch_req, ef[c]); end
      checks++; if (pc !== ep[c]) begin errors++; $display("FAIL illegal pc cycle %0d: got %h expected %h", c + 1, pc, ep[c]); end
      ins_in = (c < 2) ? I_BAD : I_ADD; ins_valid = (c != 1) && (c < 3);
    end
    checks++; if (ins !== I_ADD) begin errors++; $display("FAIL illegal resume ins: got %h expected %h", ins, I_ADD); end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_beq();
    test_fetch_stall();
    test_reset_mid_lw();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
